// File: rtl/vde_tile_store_if.sv
// Bus bundle for the VDE tile/palette store: fetcher, pixel lookup,
// CPU-side map/palette updates and the optional map-clear control.
interface vde_tile_store_if #(
  parameter int XB         = 7,
  parameter int YB         = 6,
  parameter int TILE_BITS  = 9,
  parameter int PAL_BITS   = 8,
  parameter int COLOR_BITS = 24,
  parameter int WQ_DEPTH   = 4
);
  localparam int CW = $clog2(WQ_DEPTH) + 1;

  logic [PAL_BITS-1:0]   pixel_mem_addr_i;
  logic [COLOR_BITS-1:0] pixel_mem_data_o;
  logic [XB+YB-1:0]      map_mem_addr_i;
  logic                  map_mem_fetch_i;
  logic                  map_mem_rdy_o;
  logic [TILE_BITS-1:0]  map_mem_data_o;
  logic                  map_mem_done_o;
  logic [PAL_BITS-1:0]   update_color_idx_i;
  logic [COLOR_BITS-1:0] update_color_val_i;
  logic                  update_color_upd_i;
  logic [XB-1:0]         update_map_x_i;
  logic [YB-1:0]         update_map_y_i;
  logic [TILE_BITS-1:0]  update_map_val_i;
  logic                  update_map_upd_i;
  logic                  update_map_rdy_o;
  logic [CW-1:0]         wq_count_o;
  logic                  clear_start_i;
  logic [TILE_BITS-1:0]  clear_val_i;
  logic                  clear_busy_o;

  modport master (
    output pixel_mem_addr_i, map_mem_addr_i, map_mem_fetch_i,
    output update_color_idx_i, update_color_val_i, update_color_upd_i,
    output update_map_x_i, update_map_y_i, update_map_val_i,
    output update_map_upd_i, clear_start_i, clear_val_i,
    input  pixel_mem_data_o, map_mem_rdy_o, map_mem_data_o,
    input  map_mem_done_o, update_map_rdy_o, wq_count_o, clear_busy_o
  );

  modport slave (
    input  pixel_mem_addr_i, map_mem_addr_i, map_mem_fetch_i,
    input  update_color_idx_i, update_color_val_i, update_color_upd_i,
    input  update_map_x_i, update_map_y_i, update_map_val_i,
    input  update_map_upd_i, clear_start_i, clear_val_i,
    output pixel_mem_data_o, map_mem_rdy_o, map_mem_data_o,
    output map_mem_done_o, update_map_rdy_o, wq_count_o, clear_busy_o
  );
endinterface

// File: rtl/vde_tile_store.sv
// Tile-map + palette store with a forwarding map write queue.
// Define VDE_TILE_CLEAR_EN to add the map-clear FSM.
module vde_tile_store #(
  parameter int    MAP_W      = 80,
  parameter int    MAP_H      = 64,
  parameter int    XB         = 7,
  parameter int    YB         = 6,
  parameter int    TILE_BITS  = 9,
  parameter int    PAL_BITS   = 8,
  parameter int    COLOR_BITS = 24,
  parameter int    WQ_DEPTH   = 4,
  parameter string MAP_INIT   = "",
  parameter string PAL_INIT   = ""
) (
  input logic clk_i,
  input logic rstn_i,
  vde_tile_store_if.slave bus
);
  localparam int AW    = XB + YB;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = $clog2(WQ_DEPTH);
  localparam int CW    = PW + 1;

  typedef logic [AW-1:0]        addr_t;
  typedef logic [TILE_BITS-1:0] tile_t;

  logic [COLOR_BITS-1:0] pal_mem [1 << PAL_BITS];
  tile_t                 map_mem [DEPTH];

  logic [COLOR_BITS-1:0] pix_q;

  always_ff @(posedge clk_i) begin
    if (bus.update_color_upd_i)
      pal_mem[bus.update_color_idx_i] <= bus.update_color_val_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) pix_q <= '0;
    else         pix_q <= pal_mem[bus.pixel_mem_addr_i];
  end

  addr_t         wq_addr [WQ_DEPTH];
  tile_t         wq_val  [WQ_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;

  logic  busy, clr_we;
  addr_t clr_addr;
  tile_t clr_val;

  logic  full, fetch_acc, drain, enq, enq_ok, f_oor;
  addr_t enq_addr;

  assign full     = cnt_q == CW'(WQ_DEPTH);
  assign enq_addr = {bus.update_map_y_i, bus.update_map_x_i};
  assign enq_ok   = 32'(bus.update_map_x_i) < MAP_W &&
                    32'(bus.update_map_y_i) < MAP_H;
  assign enq      = bus.update_map_upd_i && !full && !busy && enq_ok;
  assign fetch_acc = bus.map_mem_fetch_i && !full && !busy;
  assign drain    = (cnt_q != '0) && !fetch_acc;
  assign f_oor    = 32'(bus.map_mem_addr_i[XB-1:0]) >= MAP_W ||
                    32'(bus.map_mem_addr_i[AW-1:XB]) >= MAP_H;

  // Youngest matching entry wins; a same-cycle enqueue is youngest of all.
  logic  fwd_hit;
  tile_t fwd_val;
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (CW'(i) < cnt_q &&
          wq_addr[head_q + PW'(i)] == bus.map_mem_addr_i) begin
        fwd_hit = 1'b1;
        fwd_val = wq_val[head_q + PW'(i)];
      end
    end
    if (enq && enq_addr == bus.map_mem_addr_i) begin
      fwd_hit = 1'b1;
      fwd_val = bus.update_map_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      wq_addr[tail_q] <= enq_addr;
      wq_val[tail_q]  <= bus.update_map_val_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PW'(1);
      if (drain) head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + CW'(enq) - CW'(drain);
    end
  end

  logic  wr_en;
  addr_t wr_addr;
  tile_t wr_val, ram_q;

  assign wr_en   = drain || clr_we;
  assign wr_addr = drain ? wq_addr[head_q] : clr_addr;
  assign wr_val  = drain ? wq_val[head_q]  : clr_val;

  always_ff @(posedge clk_i) begin
    if (fetch_acc) ram_q <= map_mem[bus.map_mem_addr_i];
    if (wr_en)     map_mem[wr_addr] <= wr_val;
  end

  // Result selects only move on acceptance, so data holds between fetches.
  logic  done_q, zero_q, hit_q;
  tile_t fwd_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_q <= 1'b0;
      zero_q <= 1'b1;
      hit_q  <= 1'b0;
      fwd_q  <= '0;
    end else begin
      done_q <= fetch_acc;
      if (fetch_acc) begin
        zero_q <= f_oor;
        hit_q  <= fwd_hit;
        fwd_q  <= fwd_val;
      end
    end
  end

`ifdef VDE_TILE_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} clr_state_e;
  clr_state_e state_q, state_d;
  addr_t      clr_addr_q;
  tile_t      clr_val_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      clr_val_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.clear_start_i)
        clr_val_q <= bus.clear_val_i;
      if (state_q == S_CLEAR)
        clr_addr_q <= clr_addr_q + AW'(1);
    end
  end

  // Leave DRAIN once the last entry is going out this cycle.
  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.clear_start_i) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q <= CW'(1)) state_d = S_CLEAR;
      S_CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = state_q != S_IDLE;
  assign clr_addr = clr_addr_q;
  assign clr_val  = clr_val_q;
`else
  logic unused_clr;
  assign unused_clr = ^{bus.clear_start_i, bus.clear_val_i};
  assign busy       = 1'b0;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
  assign clr_val    = '0;
`endif

  assign bus.pixel_mem_data_o = pix_q;
  assign bus.map_mem_rdy_o    = !full && !busy;
  assign bus.update_map_rdy_o = !full && !busy;
  assign bus.wq_count_o       = cnt_q;
  assign bus.map_mem_done_o   = done_q;
  assign bus.map_mem_data_o   = zero_q ? '0 : (hit_q ? fwd_q : ram_q);
  assign bus.clear_busy_o     = busy;
endmodule

// File: tb/tb_vde_tile_store.sv
// Directed + randomized bench for vde_tile_store against an
// address-level "newest value wins" reference model.
module tb_vde_tile_store;
  localparam int XB = 7, YB = 6, TB = 9, PB = 8, CB = 24, WQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vde_tile_store_if #(
    .XB(XB), .YB(YB), .TILE_BITS(TB), .PAL_BITS(PB),
    .COLOR_BITS(CB), .WQ_DEPTH(WQ)
  ) bus ();

  vde_tile_store #(
    .MAP_W(80), .MAP_H(64), .XB(XB), .YB(YB), .TILE_BITS(TB),
    .PAL_BITS(PB), .COLOR_BITS(CB), .WQ_DEPTH(WQ),
    .MAP_INIT(""), .PAL_INIT("")
  ) dut (
    .clk_i(clk),
    .rstn_i(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int             mcount;
  logic [TB-1:0]  mmap [int];
  bit             cleared;
  logic [TB-1:0]  clr_v;
  bit             e_done;
  logic [TB-1:0]  e_data;
  bit             e_known;
  logic [CB-1:0]  mpal [int];
  logic [CB-1:0]  e_pix;
  bit             e_pix_known;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pixel_mem_addr_i   = '0;
    bus.map_mem_addr_i     = '0;
    bus.map_mem_fetch_i    = 1'b0;
    bus.update_color_idx_i = '0;
    bus.update_color_val_i = '0;
    bus.update_color_upd_i = 1'b0;
    bus.update_map_x_i     = '0;
    bus.update_map_y_i     = '0;
    bus.update_map_val_i   = '0;
    bus.update_map_upd_i   = 1'b0;
    bus.clear_start_i      = 1'b0;
    bus.clear_val_i        = '0;
  endtask

  task automatic fetch(int x, int y, bit en);
    bus.map_mem_fetch_i = en;
    bus.map_mem_addr_i  = 13'(y * 128 + x);
  endtask

  task automatic upd(int x, int y, int v, bit en);
    bus.update_map_upd_i = en;
    bus.update_map_x_i   = 7'(x);
    bus.update_map_y_i   = 6'(y);
    bus.update_map_val_i = 9'(v);
  endtask

  // Check current outputs, advance the model by one cycle, then clock.
  task automatic cyc();
    int  a, ux, uy;
    bit  full, facc, enq, drain;
    chk("done", 32'(bus.map_mem_done_o), 32'(e_done));
    if (e_known) chk("data", 32'(bus.map_mem_data_o), 32'(e_data));
    if (e_pix_known) chk("pix", 32'(bus.pixel_mem_data_o), 32'(e_pix));
    chk("map_rdy", 32'(bus.map_mem_rdy_o), 32'(mcount != WQ));
    chk("upd_rdy", 32'(bus.update_map_rdy_o), 32'(mcount != WQ));
    chk("count", 32'(bus.wq_count_o), 32'(mcount));
    full = (mcount == WQ);
    facc = bus.map_mem_fetch_i && !full;
    ux = int'(bus.update_map_x_i);
    uy = int'(bus.update_map_y_i);
    enq = bus.update_map_upd_i && !full && ux < 80 && uy < 64;
    if (enq) mmap[uy * 128 + ux] = bus.update_map_val_i;
    if (facc) begin
      a = int'(bus.map_mem_addr_i);
      e_done = 1'b1;
      if (a % 128 >= 80 || a / 128 >= 64) begin
        e_data = '0; e_known = 1'b1;
      end else if (mmap.exists(a)) begin
        e_data = mmap[a]; e_known = 1'b1;
      end else if (cleared) begin
        e_data = clr_v; e_known = 1'b1;
      end else begin
        e_known = 1'b0;
      end
    end else begin
      e_done = 1'b0;
    end
    drain = mcount > 0 && !facc;
    mcount = mcount + int'(enq) - int'(drain);
    a = int'(bus.pixel_mem_addr_i);
    e_pix_known = mpal.exists(a);
    if (e_pix_known) e_pix = mpal[a];
    if (bus.update_color_upd_i)
      mpal[int'(bus.update_color_idx_i)] = bus.update_color_val_i;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(bit in_range);
    int x, y;
    x = (!in_range && $urandom_range(5) == 0) ? 80 + $urandom_range(47)
                                              : $urandom_range(7);
    y = $urandom_range(3);
    fetch(x, y, 1'($urandom));
    x = (!in_range && $urandom_range(5) == 0) ? 80 + $urandom_range(47)
                                              : $urandom_range(7);
    y = $urandom_range(3);
    upd(x, y, $urandom_range(511), 1'($urandom));
    bus.pixel_mem_addr_i   = 8'($urandom_range(15));
    bus.update_color_idx_i = 8'($urandom_range(15));
    bus.update_color_val_i = 24'($urandom);
    bus.update_color_upd_i = 1'($urandom);
    cyc();
  endtask

  initial begin
    int n;
    idle();
    mcount = 0; cleared = 1'b0; clr_v = '0;
    e_done = 1'b0; e_data = '0; e_known = 1'b1; e_pix_known = 1'b0;
    #1;
    chk("rst_pix", 32'(bus.pixel_mem_data_o), 0);
    chk("rst_data", 32'(bus.map_mem_data_o), 0);
    chk("rst_done", 32'(bus.map_mem_done_o), 0);
    chk("rst_map_rdy", 32'(bus.map_mem_rdy_o), 1);
    chk("rst_upd_rdy", 32'(bus.update_map_rdy_o), 1);
    chk("rst_count", 32'(bus.wq_count_o), 0);
    chk("rst_busy", 32'(bus.clear_busy_o), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    bus.update_color_idx_i = 8'h12;
    bus.update_color_val_i = 24'hA1B2C3;
    bus.update_color_upd_i = 1'b1;
    cyc();
    bus.update_color_upd_i = 1'b0;
    bus.pixel_mem_addr_i = 8'h12;
    cyc();
    chk("pal_0x12", 32'(bus.pixel_mem_data_o), 32'h00A1B2C3);

    upd(5, 3, 'h123, 1'b1); cyc();
    upd(0, 0, 0, 1'b0); cyc();
    fetch(5, 3, 1'b1); cyc();
    chk("lat_done", 32'(bus.map_mem_done_o), 1);
    chk("lat_data", 32'(bus.map_mem_data_o), 'h123);
    fetch(0, 0, 1'b0); cyc();
    chk("lat_done_low", 32'(bus.map_mem_done_o), 0);

    upd(5, 3, 'h1AA, 1'b1); cyc();
    upd(5, 3, 'h055, 1'b1); cyc();
    upd(0, 0, 0, 1'b0);
    fetch(5, 3, 1'b1); cyc();
    chk("fwd_first", 32'(bus.map_mem_data_o), 'h055);
    cyc(); cyc();
    fetch(5, 3, 1'b0); repeat (3) cyc();
    fetch(5, 3, 1'b1); cyc();
    fetch(5, 3, 1'b0); cyc();
    chk("fwd_after_drain", 32'(bus.map_mem_data_o), 'h055);

    fetch(6, 9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      upd(i, 10, 'h100 + i, 1'b1);
      cyc();
    end
    chk("full_rdy", 32'(bus.map_mem_rdy_o), 0);
    upd(9, 10, 'h1FF, 1'b1); cyc();
    chk("full_drop", 32'(bus.wq_count_o), 3);
    upd(0, 0, 0, 1'b0);
    cyc();
    fetch(0, 0, 1'b0); repeat (4) cyc();
    fetch(3, 10, 1'b1); cyc();
    fetch(0, 0, 1'b0); cyc();

    upd(80, 0, 'h0AA, 1'b1); cyc();
    upd(0, 0, 0, 1'b0);
    chk("range_wr", 32'(bus.wq_count_o), 0);
    fetch(81, 2, 1'b1); cyc();
    fetch(0, 0, 1'b0);
    chk("range_rd", 32'(bus.map_mem_data_o), 0);
    cyc();

    for (int i = 0; i < 400; i++) rand_cycle(1'b0);

    idle();
    fetch(1, 1, 1'b1);
    upd(2, 1, 'h011, 1'b1); cyc();
    upd(3, 1, 'h022, 1'b1); cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.wq_count_o), 0);
    chk("mid_rst_done", 32'(bus.map_mem_done_o), 0);
    chk("mid_rst_rdy", 32'(bus.map_mem_rdy_o), 1);
    #1 rst_n = 1'b1;
    idle();
    mcount = 0; mmap.delete();
    e_done = 1'b0; e_data = '0; e_known = 1'b1; e_pix_known = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 60; i++) rand_cycle(1'b0);

    idle();
    fetch(1, 1, 1'b1);
    upd(20, 1, 'h0AA, 1'b1); cyc();
    upd(21, 1, 'h0BB, 1'b1); cyc();
    upd(0, 0, 0, 1'b0);
    bus.clear_start_i = 1'b1;
    bus.clear_val_i   = 9'h007;
`ifdef VDE_TILE_CLEAR_EN
    cyc();
    idle();
    chk("clr_start_done", 32'(bus.map_mem_done_o), 32'(e_done));
    n = 0;
    while (bus.clear_busy_o === 1'b1 && n < 20000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("clr_busy_cycles", 32'(n), 8194);
    mcount = 0; mmap.delete();
    cleared = 1'b1; clr_v = 9'h007; e_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fetch($urandom_range(79), $urandom_range(63), 1'b1);
      cyc();
    end
    fetch(0, 0, 1'b0); cyc();
    for (int i = 0; i < 60; i++) rand_cycle(1'b1);
`else
    cyc();
    chk("noclr_busy0", 32'(bus.clear_busy_o), 0);
    cyc();
    chk("noclr_busy1", 32'(bus.clear_busy_o), 0);
    idle();
    repeat (4) cyc();
    for (int i = 0; i < 40; i++) rand_cycle(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
